// File: rtl/mux_key_pkg.sv
// -----------------------------------------------------------------------------
// mux_key_pkg
// Shared helpers for the mux_key key-lookup multiplexer.
//
// A lookup table is a packed concatenation of NR_KEY (key, data) pairs.
// Pair 0 is the first-listed pair, so it sits in the MSBs. Inside each pair
// the key is the upper KEY_LEN bits and the data is the lower DATA_LEN bits.
//
// Contents:
//   pair_len  - bits in one (key, data) pair
//   lut_width - total width of the packed table
//   pair_msb  - bit index of the MSB of pair idx within the packed table
// -----------------------------------------------------------------------------
package mux_key_pkg;

    // Bits occupied by one (key, data) pair.
    function automatic int pair_len(input int key_len, input int data_len);
        return key_len + data_len;
    endfunction

    // Total width of a table of nr_key pairs.
    function automatic int lut_width(input int nr_key, input int key_len,
                                     input int data_len);
        return nr_key * pair_len(key_len, data_len);
    endfunction

    // MSB position of pair idx. Pair 0 starts at the top of the table.
    function automatic int pair_msb(input int idx, input int nr_key,
                                    input int key_len, input int data_len);
        return lut_width(nr_key, key_len, data_len) - 1
               - idx * pair_len(key_len, data_len);
    endfunction

endpackage : mux_key_pkg

// File: rtl/mux_key_lookup.sv
// -----------------------------------------------------------------------------
// mux_key_lookup
// Combinational priority lookup: compares key against every table key and
// returns the data of the lowest-index matching pair.
//
// Ports:
//   key   in   KEY_LEN                      lookup key
//   lut   in   NR_KEY*(KEY_LEN+DATA_LEN)    packed (key, data) table
//   data  out  DATA_LEN                     data of first match, zero if none
//   hit   out  1                            some table key equals key
// -----------------------------------------------------------------------------
module mux_key_lookup
    import mux_key_pkg::*;
#(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input  logic [KEY_LEN-1:0]                   key,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
    output logic [DATA_LEN-1:0]                  data,
    output logic                                 hit
);

    logic [KEY_LEN-1:0]  pair_key_s  [NR_KEY];
    logic [DATA_LEN-1:0] pair_data_s [NR_KEY];
    logic [NR_KEY-1:0]   match_s;
    logic [NR_KEY-1:0]   first_s;
    logic                found_s;

    // Slice the packed table into per-pair key/data fields and compare keys.
    for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_pair
        localparam int MSB = pair_msb(gi, NR_KEY, KEY_LEN, DATA_LEN);
        assign pair_key_s[gi]  = lut[MSB -: KEY_LEN];
        assign pair_data_s[gi] = lut[MSB-KEY_LEN -: DATA_LEN];
        assign match_s[gi]     = (pair_key_s[gi] == key);
    end

    // One-hot mask of the first (lowest-index) matching pair.
    always_comb begin
        first_s = {NR_KEY{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (match_s[i] && !found_s) begin
                first_s[i] = 1'b1;
                found_s    = 1'b1;
            end else begin
                first_s[i] = 1'b0;
            end
        end
    end

    // AND-OR select: data of pairs outside the one-hot mask is forced to
    // zero, so unknown or stale data in unmatched pairs cannot leak out.
    always_comb begin
        data = {DATA_LEN{1'b0}};
        for (int i = 0; i < NR_KEY; i++) begin
            data = data | (pair_data_s[i] & {DATA_LEN{first_s[i]}});
        end
        hit = found_s;
    end

endmodule : mux_key_lookup

// File: rtl/mux_key.sv
// -----------------------------------------------------------------------------
// mux_key
// Parameterised key-lookup multiplexer used as a generic decoder/selector.
// Drives the data of the first table pair whose key equals key; on no match
// drives default_out (HAS_DEFAULT=1) or zero (HAS_DEFAULT=0). The result is
// either combinational (OUT_REG=0) or registered on clk (OUT_REG=1).
//
// Ports:
//   clk          in   1                           clock (OUT_REG=1 only)
//   rst_n        in   1                           sync active-low reset
//                                                  (OUT_REG=1 only)
//   key          in   KEY_LEN                     lookup key
//   default_out  in   DATA_LEN                    value on no match
//   lut          in   NR_KEY*(KEY_LEN+DATA_LEN)   packed table, pair 0 in MSBs
//   out          out  DATA_LEN                    selected data
//   hit          out  1                           a table key matched
// -----------------------------------------------------------------------------
module mux_key
    import mux_key_pkg::*;
#(
    parameter int NR_KEY      = 2,
    parameter int KEY_LEN     = 1,
    parameter int DATA_LEN    = 1,
    parameter int HAS_DEFAULT = 0,
    parameter int OUT_REG     = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [KEY_LEN-1:0]                   key,
    input  logic [DATA_LEN-1:0]                  default_out,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
    output logic [DATA_LEN-1:0]                  out,
    output logic                                 hit
);

    logic [DATA_LEN-1:0] lookup_data_s;
    logic                lookup_hit_s;
    logic [DATA_LEN-1:0] select_s;

    mux_key_lookup #(
        .NR_KEY   (NR_KEY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN)
    ) u_lookup (
        .key  (key),
        .lut  (lut),
        .data (lookup_data_s),
        .hit  (lookup_hit_s)
    );

    // Replace the (zero) lookup result with default_out on a miss when enabled.
    always_comb begin
        if (lookup_hit_s) begin
            select_s = lookup_data_s;
        end else if (HAS_DEFAULT != 0) begin
            select_s = default_out;
        end else begin
            select_s = {DATA_LEN{1'b0}};
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_LEN-1:0] out_r;
        logic                hit_r;

        // Output register: reset wins; otherwise capture every cycle.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                out_r <= {DATA_LEN{1'b0}};
                hit_r <= 1'b0;
            end else begin
                out_r <= select_s;
                hit_r <= lookup_hit_s;
            end
        end

        assign out = out_r;
        assign hit = hit_r;
    end else begin : g_out_comb
        // Clock and reset are intentionally unused in the combinational build.
        logic unused_s;
        assign unused_s = clk ^ rst_n;

        assign out = select_s;
        assign hit = lookup_hit_s;
    end

endmodule : mux_key

// File: tb/tb_mux_key.sv
// -----------------------------------------------------------------------------
// tb_mux_key
// Self-checking bench for mux_key. Four instances cover the combinational
// table, the default-value variant, duplicate keys and the registered output.
// Expected results are pushed to a scoreboard when stimulus is driven and
// popped when the corresponding DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_mux_key;

    typedef struct {
        string      tag;
        logic [3:0] out;
        logic       hit;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    // 7-entry table: {000:00, 001:10, 010:11, 100:10, 101:10, 110:00, 111:00}
    localparam logic [34:0] TABLE7 = {3'b000, 2'b00, 3'b001, 2'b10,
                                      3'b010, 2'b11, 3'b100, 2'b10,
                                      3'b101, 2'b10, 3'b110, 2'b00,
                                      3'b111, 2'b00};

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic [2:0]  key7    = 3'b000;
    logic [2:0]  key_r   = 3'b000;
    logic [1:0]  dflt7   = 2'b01;
    logic [34:0] lut7    = TABLE7;
    logic [1:0]  key_dup = 2'b00;
    logic [3:0]  dflt_dup = 4'hF;
    logic [17:0] lut_dup = {2'b01, 4'hA, 2'b01, 4'h5, 2'b10, 4'h3};

    logic [1:0] out_c, out_d, out_r;
    logic       hit_c, hit_d, hit_r;
    logic [3:0] out_dup;
    logic       hit_dup;

    always #5 clk = ~clk;

    mux_key #(.NR_KEY(7), .KEY_LEN(3), .DATA_LEN(2), .HAS_DEFAULT(0), .OUT_REG(0))
    u_comb (.clk(clk), .rst_n(rst_n), .key(key7), .default_out(dflt7),
            .lut(lut7), .out(out_c), .hit(hit_c));

    mux_key #(.NR_KEY(7), .KEY_LEN(3), .DATA_LEN(2), .HAS_DEFAULT(1), .OUT_REG(0))
    u_def (.clk(clk), .rst_n(rst_n), .key(key7), .default_out(dflt7),
           .lut(lut7), .out(out_d), .hit(hit_d));

    mux_key #(.NR_KEY(7), .KEY_LEN(3), .DATA_LEN(2), .HAS_DEFAULT(0), .OUT_REG(1))
    u_reg (.clk(clk), .rst_n(rst_n), .key(key_r), .default_out(dflt7),
           .lut(lut7), .out(out_r), .hit(hit_r));

    mux_key #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(4), .HAS_DEFAULT(0), .OUT_REG(0))
    u_dup (.clk(clk), .rst_n(rst_n), .key(key_dup), .default_out(dflt_dup),
           .lut(lut_dup), .out(out_dup), .hit(hit_dup));

    // Reference model for the 7x(3,2) table: scan pairs from 0 upward and
    // return {hit, data} for the first exact key match.
    function automatic logic [2:0] ref7(input logic [2:0] k, input logic [34:0] t,
                                        input logic has_def, input logic [1:0] d);
        logic [4:0] pair;
        for (int i = 0; i < 7; i++) begin
            pair = t[34-5*i -: 5];
            if (pair[4:2] == k) return {1'b1, pair[1:0]};
        end
        return {1'b0, (has_def ? d : 2'b00)};
    endfunction

    task automatic push_exp(input string tag, input logic [3:0] o, input logic h);
        exp_t e;
        e.tag = tag;
        e.out = o;
        e.hit = h;
        sb.push_back(e);
    endtask

    task automatic check_pop(input logic [3:0] o, input logic h);
        exp_t e;
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL scoreboard_empty: out=%h hit=%b with no expected entry", o, h);
        end else begin
            e = sb.pop_front();
            assert (o === e.out && h === e.hit)
            else begin
                tests_failed++;
                $error("FAIL %s: out=%h hit=%b, required out=%h hit=%b",
                       e.tag, o, h, e.out, e.hit);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] r0, r1;

        // --- combinational lookups on the 7-entry table ---
        key7 = 3'b010; push_exp("c_key010", 4'h3, 1'b1); #1; check_pop({2'b00, out_c}, hit_c);
        key7 = 3'b001; push_exp("c_key001", 4'h2, 1'b1); #1; check_pop({2'b00, out_c}, hit_c);
        key7 = 3'b011; push_exp("c_key011_miss", 4'h0, 1'b0); #1; check_pop({2'b00, out_c}, hit_c);

        // --- default value variant ---
        key7 = 3'b011; push_exp("d_key011_default", 4'h1, 1'b0); #1; check_pop({2'b00, out_d}, hit_d);
        key7 = 3'b000; push_exp("d_key000_zero_hit", 4'h0, 1'b1); #1; check_pop({2'b00, out_d}, hit_d);

        // --- sweep every key through both variants against the model ---
        for (int k = 0; k < 8; k++) begin
            key7 = 3'(k);
            r0 = ref7(3'(k), lut7, 1'b0, dflt7);
            r1 = ref7(3'(k), lut7, 1'b1, dflt7);
            push_exp($sformatf("sweep_c_%0d", k), {2'b00, r0[1:0]}, r0[2]);
            push_exp($sformatf("sweep_d_%0d", k), {2'b00, r1[1:0]}, r1[2]);
            #1;
            check_pop({2'b00, out_c}, hit_c);
            check_pop({2'b00, out_d}, hit_d);
        end

        // --- duplicate keys: first-listed pair wins, no ORing ---
        key_dup = 2'b01; push_exp("dup_first_wins", 4'hA, 1'b1); #1; check_pop(out_dup, hit_dup);
        key_dup = 2'b10; push_exp("dup_last_pair", 4'h3, 1'b1); #1; check_pop(out_dup, hit_dup);
        key_dup = 2'b00; push_exp("dup_miss_ignores_default", 4'h0, 1'b0); #1; check_pop(out_dup, hit_dup);

        // --- live table update: pair 4 (key 101) data 10 -> 01 ---
        key7 = 3'b101; push_exp("live_before", 4'h2, 1'b1); #1; check_pop({2'b00, out_c}, hit_c);
        lut7[11:10] = 2'b01;
        push_exp("live_after", 4'h1, 1'b1); #1; check_pop({2'b00, out_c}, hit_c);
        lut7 = TABLE7;

        // --- registered output ---
        @(negedge clk);
        rst_n = 1'b0;
        key_r = 3'b010;
        push_exp("r_reset_hold", 4'h0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_pop({2'b00, out_r}, hit_r);

        rst_n = 1'b1;
        push_exp("r_not_before_edge", 4'h0, 1'b0);
        #3;
        check_pop({2'b00, out_r}, hit_r);
        push_exp("r_latency_one", 4'h3, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_pop({2'b00, out_r}, hit_r);

        key_r = 3'b100;
        push_exp("r_hold_until_edge", 4'h3, 1'b1);
        #3;
        check_pop({2'b00, out_r}, hit_r);
        push_exp("r_key100", 4'h2, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_pop({2'b00, out_r}, hit_r);

        key_r = 3'b010;
        push_exp("r_key010_again", 4'h3, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_pop({2'b00, out_r}, hit_r);

        // Reset mid-stream while key stays 010; comb path must not care.
        rst_n = 1'b0;
        key7  = 3'b010;
        push_exp("r_mid_reset", 4'h0, 1'b0);
        push_exp("c_ignores_reset", 4'h3, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_pop({2'b00, out_r}, hit_r);
        check_pop({2'b00, out_c}, hit_c);

        rst_n = 1'b1;
        push_exp("r_after_reset", 4'h3, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check_pop({2'b00, out_r}, hit_r);

        // Every pushed expectation must have been consumed.
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_leftover: %0d entries left, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_mux_key
